// File: rtl/dac_spi_responder.sv
// Device-side model of the LTC2624 quad-DAC SPI link: oversamples the SPI pins on CLK50MHZ,
// decodes 32-bit frames into per-channel input/DAC registers and echoes the prior frame on SDO.
module dac_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        CLK50MHZ,
  input  logic        RST,
  input  logic        SPI_SCK,
  input  logic        DAC_CS,
  input  logic        SPI_MOSI,
  input  logic        DAC_CLR,
  output logic        DAC_OUT,
  output logic [47:0] dac_value,
  output logic [3:0]  dac_pd,
  output logic        update,
  output logic [3:0]  update_mask,
  output logic        frame_err,
  output logic [3:0]  last_cmd,
  output logic [3:0]  last_addr
);

  localparam int unsigned SyncW = 4 * SYNC_STAGES;

  // Each synchronizer stage holds {clr, cs, mosi, sck}; reset to the idle bus state.
  logic [SyncW-1:0] sync_q;
  logic [3:0]       pins_s;
  logic             sck_prev_q, cs_prev_q;

  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      sync_q     <= {SYNC_STAGES{4'b1100}};
      sck_prev_q <= 1'b0;
      cs_prev_q  <= 1'b1;
    end else begin
      sync_q     <= {sync_q[SyncW-5:0], DAC_CLR, DAC_CS, SPI_MOSI, SPI_SCK};
      sck_prev_q <= pins_s[0];
      cs_prev_q  <= pins_s[2];
    end
  end

  assign pins_s = sync_q[SyncW-1 -: 4];

  logic sck_rise, sck_fall, cs_rise, cs_fall, clr_act, mosi_s, cs_low;
  assign sck_rise = pins_s[0] & ~sck_prev_q;
  assign sck_fall = ~pins_s[0] & sck_prev_q;
  assign cs_fall  = ~pins_s[2] & cs_prev_q;
  assign cs_rise  = pins_s[2] & ~cs_prev_q;
  assign cs_low   = ~pins_s[2];
  assign clr_act  = ~pins_s[3];
  assign mosi_s   = pins_s[1];

  logic              open_q, open_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [31:0]       rx_q, rx_d;
  logic [31:0]       tx_q, tx_d;
  logic [31:0]       echo_q, echo_d;
  logic [3:0][11:0]  in_q, in_d;
  logic [3:0][11:0]  dac_q, dac_d;
  logic [3:0]        pd_q, pd_d;
  logic              update_q, update_d;
  logic [3:0]        mask_q, mask_d;
  logic              err_q, err_d;
  logic [3:0]        last_cmd_q, last_cmd_d;
  logic [3:0]        last_addr_q, last_addr_d;

  logic [3:0]  f_cmd, f_addr, sel, wmask;
  logic [11:0] f_data;
  assign f_cmd  = rx_q[23:20];
  assign f_addr = rx_q[19:16];
  assign f_data = rx_q[15:4];

  always_comb begin
    unique case (f_addr)
      4'b0000: sel = 4'b0001;
      4'b0001: sel = 4'b0010;
      4'b0010: sel = 4'b0100;
      4'b0011: sel = 4'b1000;
      4'b1111: sel = 4'b1111;
      default: sel = 4'b0000;
    endcase
  end

  always_comb begin
    open_d      = open_q;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    echo_d      = echo_q;
    in_d        = in_q;
    dac_d       = dac_q;
    pd_d        = pd_q;
    update_d    = 1'b0;
    mask_d      = 4'b0000;
    err_d       = 1'b0;
    last_cmd_d  = last_cmd_q;
    last_addr_d = last_addr_q;
    wmask       = 4'b0000;

    // Clear wins over everything, including a CS rising edge in the same cycle.
    if (clr_act) begin
      open_d = 1'b0;
      in_d   = '0;
      dac_d  = '0;
      pd_d   = '0;
    end else if (cs_fall) begin
      open_d = 1'b1;
      cnt_d  = 6'd0;
      rx_d   = 32'd0;
      tx_d   = echo_q;
    end else if (open_q) begin
      if (cs_rise) begin
        open_d = 1'b0;
        if (cnt_q == 6'd32) begin
          echo_d      = rx_q;
          last_cmd_d  = f_cmd;
          last_addr_d = f_addr;
          case (f_cmd)
            4'b0000: begin
              for (int n = 0; n < 4; n++) if (sel[n]) in_d[n] = f_data;
            end
            4'b0001: begin
              for (int n = 0; n < 4; n++) if (sel[n]) begin
                dac_d[n] = in_q[n];
                pd_d[n]  = 1'b0;
              end
              wmask = sel;
            end
            4'b0010: begin
              for (int n = 0; n < 4; n++) if (sel[n]) in_d[n] = f_data;
              dac_d = in_d;
              pd_d  = 4'b0000;
              wmask = 4'b1111;
            end
            4'b0011: begin
              for (int n = 0; n < 4; n++) if (sel[n]) begin
                in_d[n]  = f_data;
                dac_d[n] = f_data;
                pd_d[n]  = 1'b0;
              end
              wmask = sel;
            end
            4'b0100: pd_d = pd_q | sel;
            default: ;
          endcase
          update_d = |wmask;
          mask_d   = wmask;
        end else begin
          err_d = 1'b1;
        end
      end else if (cs_low) begin
        if (sck_rise) begin
          rx_d = {rx_q[30:0], mosi_s};
          if (cnt_q != 6'd33) cnt_d = cnt_q + 6'd1;
        end
        if (sck_fall) tx_d = {tx_q[30:0], 1'b0};
      end
    end
  end

  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      open_q      <= 1'b0;
      cnt_q       <= 6'd0;
      rx_q        <= 32'd0;
      tx_q        <= 32'd0;
      echo_q      <= 32'd0;
      in_q        <= '0;
      dac_q       <= '0;
      pd_q        <= 4'b0000;
      update_q    <= 1'b0;
      mask_q      <= 4'b0000;
      err_q       <= 1'b0;
      last_cmd_q  <= 4'b0000;
      last_addr_q <= 4'b0000;
    end else begin
      open_q      <= open_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      echo_q      <= echo_d;
      in_q        <= in_d;
      dac_q       <= dac_d;
      pd_q        <= pd_d;
      update_q    <= update_d;
      mask_q      <= mask_d;
      err_q       <= err_d;
      last_cmd_q  <= last_cmd_d;
      last_addr_q <= last_addr_d;
    end
  end

  assign DAC_OUT     = tx_q[31];
  assign dac_value   = dac_q;
  assign dac_pd      = pd_q;
  assign update      = update_q;
  assign update_mask = mask_q;
  assign frame_err   = err_q;
  assign last_cmd    = last_cmd_q;
  assign last_addr   = last_addr_q;

endmodule

// File: tb/tb_dac_spi_responder.sv
// Directed bench for dac_spi_responder: a vector table of SPI frames plus hand sequences for
// echo timing and the DAC_CLR abort.
module tb_dac_spi_responder;

  localparam int unsigned Sync = 2;
  localparam int Half = 8;

  logic        clk = 1'b0;
  logic        rst, sck, cs, mosi, clr;
  logic        dac_out;
  logic [47:0] dac_value;
  logic [3:0]  dac_pd, update_mask, last_cmd, last_addr;
  logic        update, frame_err;

  dac_spi_responder #(.SYNC_STAGES(Sync)) u_dut (
    .CLK50MHZ   (clk),
    .RST        (rst),
    .SPI_SCK    (sck),
    .DAC_CS     (cs),
    .SPI_MOSI   (mosi),
    .DAC_CLR    (clr),
    .DAC_OUT    (dac_out),
    .dac_value  (dac_value),
    .dac_pd     (dac_pd),
    .update     (update),
    .update_mask(update_mask),
    .frame_err  (frame_err),
    .last_cmd   (last_cmd),
    .last_addr  (last_addr)
  );

  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int upd_total = 0;
  int err_total = 0;
  logic [3:0] mask_seen = 4'b0000;

  // Counting every high cycle catches pulses that stick for more than one cycle.
  always @(negedge clk) begin
    if (update) begin
      upd_total <= upd_total + 1;
      mask_seen <= update_mask;
    end
    if (frame_err) err_total <= err_total + 1;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] c, input logic [3:0] a,
                                     input logic [11:0] d);
    return {8'h00, c, a, d, 4'h0};
  endfunction

  // Drives one frame of nbits bits; DAC_OUT is captured at each SCK rising edge.
  task automatic send_frame(input logic [31:0] word, input int nbits, input int clr_at,
                            output logic [31:0] cap);
    cap = 32'd0;
    cs = 1'b0;
    cyc(Half);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 32) ? word[31-i] : 1'b0;
      if (i == clr_at) begin
        clr = 1'b0;
        cyc(10);
        clr = 1'b1;
      end
      cyc(Half);
      sck = 1'b1;
      if (i < 32) cap = {cap[30:0], dac_out};
      cyc(Half);
      sck = 1'b0;
    end
    cyc(Half);
    cs = 1'b1;
    cyc(12);
  endtask

  typedef struct {
    logic [3:0]  cmd;
    logic [3:0]  addr;
    logic [11:0] data;
    int          nbits;
    logic [47:0] dac;
    logic [3:0]  pd;
    int          upd;
    logic [3:0]  mask;
    int          err;
    logic [3:0]  lcmd;
    logic [3:0]  laddr;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [31:0] cap, exp_echo, word;
    int u0, e0;

    vecs[0] = '{4'h3, 4'h0, 12'h800, 32, 48'h000000000800, 4'h0, 1, 4'h1, 0, 4'h3, 4'h0};
    vecs[1] = '{4'h0, 4'h1, 12'h123, 32, 48'h000000000800, 4'h0, 0, 4'h0, 0, 4'h0, 4'h1};
    vecs[2] = '{4'h1, 4'h1, 12'h000, 32, 48'h000000123800, 4'h0, 1, 4'h2, 0, 4'h1, 4'h1};
    vecs[3] = '{4'h4, 4'h2, 12'h000, 32, 48'h000000123800, 4'h4, 0, 4'h0, 0, 4'h4, 4'h2};
    vecs[4] = '{4'h3, 4'hF, 12'hFFF, 32, 48'hFFFFFFFFFFFF, 4'h0, 1, 4'hF, 0, 4'h3, 4'hF};
    vecs[5] = '{4'h0, 4'h0, 12'h555, 20, 48'hFFFFFFFFFFFF, 4'h0, 0, 4'h0, 1, 4'h3, 4'hF};
    vecs[6] = '{4'h3, 4'h0, 12'h000, 33, 48'hFFFFFFFFFFFF, 4'h0, 0, 4'h0, 1, 4'h3, 4'hF};
    vecs[7] = '{4'h2, 4'h2, 12'h456, 32, 48'hFFF456FFFFFF, 4'h0, 1, 4'hF, 0, 4'h2, 4'h2};
    vecs[8] = '{4'h3, 4'h5, 12'h111, 32, 48'hFFF456FFFFFF, 4'h0, 0, 4'h0, 0, 4'h3, 4'h5};

    rst = 1'b1; sck = 1'b0; cs = 1'b1; mosi = 1'b0; clr = 1'b1;
    cyc(5);
    rst = 1'b0;
    cyc(4);
    check("reset dac_out", {47'd0, dac_out}, 48'd0);
    check("reset dac_value", dac_value, 48'd0);
    check("reset dac_pd", {44'd0, dac_pd}, 48'd0);
    check("reset pulses", {46'd0, update, frame_err}, 48'd0);
    check("reset last", {40'd0, last_cmd, last_addr}, 48'd0);

    exp_echo = 32'd0;
    for (int v = 0; v < 9; v++) begin
      u0 = upd_total;
      e0 = err_total;
      word = mk(vecs[v].cmd, vecs[v].addr, vecs[v].data);
      send_frame(word, vecs[v].nbits, -1, cap);
      check($sformatf("v%0d dac_value", v), dac_value, vecs[v].dac);
      check($sformatf("v%0d dac_pd", v), {44'd0, dac_pd}, {44'd0, vecs[v].pd});
      check($sformatf("v%0d update count", v), 48'(upd_total - u0), 48'(vecs[v].upd));
      if (vecs[v].upd != 0)
        check($sformatf("v%0d update_mask", v), {44'd0, mask_seen}, {44'd0, vecs[v].mask});
      check($sformatf("v%0d frame_err count", v), 48'(err_total - e0), 48'(vecs[v].err));
      check($sformatf("v%0d last_cmd", v), {44'd0, last_cmd}, {44'd0, vecs[v].lcmd});
      check($sformatf("v%0d last_addr", v), {44'd0, last_addr}, {44'd0, vecs[v].laddr});
      if (vecs[v].nbits >= 32)
        check($sformatf("v%0d echo", v), {16'd0, cap}, {16'd0, exp_echo});
      else
        check($sformatf("v%0d echo", v), {16'd0, cap},
              {16'd0, exp_echo >> (32 - vecs[v].nbits)});
      if (vecs[v].nbits == 32) exp_echo = word;
    end

    // Echo of frame X read back during frame Y.
    send_frame(32'h0030ABC0, 32, -1, cap);
    send_frame(32'h80F00000, 32, -1, cap);
    check("echo X during Y", {16'd0, cap}, 48'h00000030ABC0);
    check("nop last_cmd", {44'd0, last_cmd}, 48'hF);
    check("abc in A", {36'd0, dac_value[11:0]}, 48'hABC);

    // Bit 31 of the echo must appear before any SCK edge.
    e0 = err_total;
    cs = 1'b0;
    cyc(Sync + 3);
    check("echo bit31 at cs fall", {47'd0, dac_out}, 48'd1);
    cs = 1'b1;
    cyc(12);
    check("empty frame err", 48'(err_total - e0), 48'd1);

    // DAC_CLR mid-frame clears input/dac/pd and drops the rest of the frame.
    send_frame(mk(4'h3, 4'h0, 12'h800), 32, -1, cap);
    send_frame(mk(4'h0, 4'h1, 12'h555), 32, -1, cap);
    send_frame(mk(4'h4, 4'h3, 12'h000), 32, -1, cap);
    check("pre-clr A", {36'd0, dac_value[11:0]}, 48'h800);
    check("pre-clr pd", {44'd0, dac_pd}, 48'h8);
    u0 = upd_total;
    e0 = err_total;
    send_frame(mk(4'h3, 4'h1, 12'h777), 32, 10, cap);
    check("clr dac_value", dac_value, 48'd0);
    check("clr dac_pd", {44'd0, dac_pd}, 48'd0);
    check("clr no update", 48'(upd_total - u0), 48'd0);
    check("clr no frame_err", 48'(err_total - e0), 48'd0);
    check("clr last_cmd kept", {44'd0, last_cmd}, 48'h4);

    // Input register B was cleared, so loading it must yield zero with mask 0010.
    u0 = upd_total;
    send_frame(mk(4'h3, 4'h2, 12'h321), 32, -1, cap);
    send_frame(mk(4'h1, 4'h1, 12'h000), 32, -1, cap);
    check("post-clr dac_value", dac_value, 48'h000321000000);
    check("post-clr updates", 48'(upd_total - u0), 48'd2);
    check("post-clr mask", {44'd0, mask_seen}, 48'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
